// File: rtl/priority_scanner_if.sv
// Handshake bundle for priority_scanner: word input side and per-bit beat output side.
// The scanner takes the slave modport; the producer/consumer pair takes master.
interface priority_scanner_if #(
  parameter int WIDTH = 16
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] data_i;
  logic             msb_first_i;
  logic             data_val_i;
  logic             data_rdy_o;

  logic [WIDTH-1:0] onehot_o;
  logic [IDX_W-1:0] idx_o;
  logic [CNT_W-1:0] cnt_o;
  logic             last_o;
  logic             zero_o;
  logic             val_o;
  logic             rdy_i;

  modport slave (
    input  data_i, msb_first_i, data_val_i, rdy_i,
    output data_rdy_o, onehot_o, idx_o, cnt_o, last_o, zero_o, val_o
  );

  modport master (
    output data_i, msb_first_i, data_val_i, rdy_i,
    input  data_rdy_o, onehot_o, idx_o, cnt_o, last_o, zero_o, val_o
  );
endinterface

// File: rtl/priority_scanner.sv
// Serialises every set bit of an accepted word, one beat per handshake, in
// MSB-first or LSB-first order chosen per word.
module priority_scanner #(
  parameter int WIDTH = 16
) (
  input logic             clk_i,
  input logic             rst_n_i,
  priority_scanner_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] resid_q, resid_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;

  logic             inScan;
  logic [WIDTH-1:0] ordered;
  logic [WIDTH-1:0] isolated;
  logic [WIDTH-1:0] onehotSel;
  logic [IDX_W-1:0] idxSel;
  logic             lastSel;
  logic             dataRdy;
  logic [CNT_W-1:0] popCnt;

  function automatic logic [WIDTH-1:0] bitRev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = x[WIDTH-1-i];
    end
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      resid_q <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      resid_q <= resid_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  // MSB-first reuses the isolate-lowest trick on the bit-reversed residual.
  always_comb begin
    inScan    = (state_q == SCAN);
    ordered   = mode_q ? bitRev(resid_q) : resid_q;
    isolated  = ordered & (~ordered + WIDTH'(1));
    onehotSel = mode_q ? bitRev(isolated) : isolated;
    idxSel    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehotSel[i]) begin
        idxSel = idxSel | IDX_W'(i);
      end
    end
    lastSel = zero_q | ((resid_q & (resid_q - WIDTH'(1))) == '0);
    dataRdy = !inScan | (bus.rdy_i & lastSel);

    bus.val_o      = inScan;
    bus.onehot_o   = inScan ? onehotSel : '0;
    bus.idx_o      = inScan ? idxSel : '0;
    bus.cnt_o      = inScan ? cnt_q : '0;
    bus.last_o     = inScan & lastSel;
    bus.zero_o     = inScan & zero_q;
    bus.data_rdy_o = dataRdy;
  end

  always_comb begin
    state_d = state_q;
    resid_d = resid_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    popCnt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popCnt = popCnt + CNT_W'(bus.data_i[i]);
    end

    if (inScan && bus.rdy_i) begin
      resid_d = resid_q & ~onehotSel;
      if (lastSel) begin
        state_d = IDLE;
      end
    end

    // A new word may load on the same edge that retires the previous last beat.
    if (bus.data_val_i && dataRdy) begin
      state_d = SCAN;
      resid_d = bus.data_i;
      mode_d  = bus.msb_first_i;
      cnt_d   = popCnt;
      zero_d  = (bus.data_i == '0);
    end
  end
endmodule

// File: tb/tb_priority_scanner.sv
// Directed scenarios for priority_scanner at WIDTH=16; inputs change and
// outputs are sampled around the falling clock edge.
module tb_priority_scanner;
  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  priority_scanner_if #(.WIDTH(16)) bus ();

  priority_scanner #(.WIDTH(16)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    bus.data_i = '0;
    bus.msb_first_i = 1'b0;
    bus.data_val_i = 1'b0;
    bus.rdy_i = 1'b1;
    #12;
    checkCount++;
    if (bus.val_o !== 1'b0) begin errorCount++; $display("[TB] FAIL reset val_o got %b expected 0", bus.val_o); end
    checkCount++;
    if (bus.onehot_o !== 16'h0) begin errorCount++; $display("[TB] FAIL reset onehot_o got %h expected 0000", bus.onehot_o); end
    checkCount++;
    if (bus.idx_o !== 4'd0) begin errorCount++; $display("[TB] FAIL reset idx_o got %0d expected 0", bus.idx_o); end
    checkCount++;
    if (bus.cnt_o !== 5'd0) begin errorCount++; $display("[TB] FAIL reset cnt_o got %0d expected 0", bus.cnt_o); end
    checkCount++;
    if (bus.last_o !== 1'b0) begin errorCount++; $display("[TB] FAIL reset last_o got %b expected 0", bus.last_o); end
    checkCount++;
    if (bus.zero_o !== 1'b0) begin errorCount++; $display("[TB] FAIL reset zero_o got %b expected 0", bus.zero_o); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkCount++;
    if (bus.data_rdy_o !== 1'b1) begin errorCount++; $display("[TB] FAIL reset data_rdy_o got %b expected 1", bus.data_rdy_o); end
  endtask

  task automatic test_scan_order(input logic msbFirst);
    int idxList[4] = '{0, 5, 10, 15};
    int idxVal;
    logic [27:0] expBeat;
    @(negedge clk);
    bus.data_i = 16'h8421;
    bus.msb_first_i = msbFirst;
    bus.data_val_i = 1'b1;
    bus.rdy_i = 1'b1;
    #1;
    checkCount++;
    if ({bus.val_o, bus.data_rdy_o} !== 2'b01) begin
      errorCount++;
      $display("[TB] FAIL order pre-accept val/rdy got %b expected 01", {bus.val_o, bus.data_rdy_o});
    end
    @(negedge clk);
    bus.data_val_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      idxVal = msbFirst ? idxList[3-k] : idxList[k];
      expBeat = {16'd1 << idxVal, 4'(idxVal), 5'd4, (k == 3), 1'b0, 1'b1};
      checkCount++;
      if ({bus.onehot_o, bus.idx_o, bus.cnt_o, bus.last_o, bus.zero_o, bus.val_o} !== expBeat) begin
        errorCount++;
        $display("[TB] FAIL order msb=%b beat %0d got %h expected %h", msbFirst, k,
                 {bus.onehot_o, bus.idx_o, bus.cnt_o, bus.last_o, bus.zero_o, bus.val_o}, expBeat);
      end
      @(negedge clk);
    end
    #1;
    checkCount++;
    if ({bus.val_o, bus.data_rdy_o} !== 2'b01) begin
      errorCount++;
      $display("[TB] FAIL order msb=%b idle val/rdy got %b expected 01", msbFirst, {bus.val_o, bus.data_rdy_o});
    end
  endtask

  task automatic test_zero_word();
    @(negedge clk);
    bus.data_i = 16'h0000;
    bus.msb_first_i = 1'b1;
    bus.data_val_i = 1'b1;
    bus.rdy_i = 1'b1;
    @(negedge clk);
    bus.data_val_i = 1'b0;
    #1;
    checkCount++;
    if ({bus.onehot_o, bus.idx_o, bus.cnt_o, bus.last_o, bus.zero_o, bus.val_o} !== {16'h0, 4'd0, 5'd0, 1'b1, 1'b1, 1'b1}) begin
      errorCount++;
      $display("[TB] FAIL zero beat got %h expected %h",
               {bus.onehot_o, bus.idx_o, bus.cnt_o, bus.last_o, bus.zero_o, bus.val_o}, {16'h0, 4'd0, 5'd0, 1'b1, 1'b1, 1'b1});
    end
    @(negedge clk);
    #1;
    checkCount++;
    if ({bus.val_o, bus.data_rdy_o} !== 2'b01) begin
      errorCount++;
      $display("[TB] FAIL zero idle val/rdy got %b expected 01", {bus.val_o, bus.data_rdy_o});
    end
  endtask

  task automatic test_backpressure();
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [27:0] expBeat;
    int k = 0;
    int c = 0;
    @(negedge clk);
    bus.data_i = 16'h00F0;
    bus.msb_first_i = 1'b0;
    bus.data_val_i = 1'b1;
    bus.rdy_i = 1'b1;
    @(negedge clk);
    // Next word stays offered throughout; it must only load with the last beat.
    bus.data_i = 16'h0100;
    bus.msb_first_i = 1'b1;
    while (k < 4 && c < 40) begin
      bus.rdy_i = pat[c % 4];
      #1;
      expBeat = {16'd1 << (4 + k), 4'(4 + k), 5'd4, (k == 3), 1'b0, 1'b1};
      checkCount++;
      if ({bus.onehot_o, bus.idx_o, bus.cnt_o, bus.last_o, bus.zero_o, bus.val_o} !== expBeat) begin
        errorCount++;
        $display("[TB] FAIL backpressure cycle %0d got %h expected %h", c,
                 {bus.onehot_o, bus.idx_o, bus.cnt_o, bus.last_o, bus.zero_o, bus.val_o}, expBeat);
      end
      checkCount++;
      if (bus.data_rdy_o !== (bus.rdy_i && k == 3)) begin
        errorCount++;
        $display("[TB] FAIL backpressure data_rdy cycle %0d got %b expected %b", c, bus.data_rdy_o, (bus.rdy_i && k == 3));
      end
      if (bus.rdy_i) k++;
      c++;
      @(negedge clk);
    end
    checkCount++;
    if (k != 4) begin
      errorCount++;
      $display("[TB] FAIL backpressure beats consumed got %0d expected 4", k);
    end
    bus.data_val_i = 1'b0;
    bus.rdy_i = 1'b1;
    #1;
    checkCount++;
    if ({bus.onehot_o, bus.idx_o, bus.cnt_o, bus.last_o, bus.zero_o, bus.val_o} !== {16'h0100, 4'd8, 5'd1, 1'b1, 1'b0, 1'b1}) begin
      errorCount++;
      $display("[TB] FAIL backpressure follow-on got %h expected %h",
               {bus.onehot_o, bus.idx_o, bus.cnt_o, bus.last_o, bus.zero_o, bus.val_o}, {16'h0100, 4'd8, 5'd1, 1'b1, 1'b0, 1'b1});
    end
    @(negedge clk);
    #1;
    checkCount++;
    if (bus.val_o !== 1'b0) begin errorCount++; $display("[TB] FAIL backpressure tail val_o got %b expected 0", bus.val_o); end
  endtask

  task automatic test_back_to_back();
    logic [27:0] expBeat;
    int idxVal;
    @(negedge clk);
    bus.data_i = 16'h0003;
    bus.msb_first_i = 1'b0;
    bus.data_val_i = 1'b1;
    bus.rdy_i = 1'b1;
    @(negedge clk);
    bus.data_i = 16'hFFFF;
    bus.msb_first_i = 1'b1;
    for (int b = 0; b < 18; b++) begin
      if (b == 2) bus.data_val_i = 1'b0;
      #1;
      if (b < 2) begin
        idxVal = b;
        expBeat = {16'd1 << idxVal, 4'(idxVal), 5'd2, (b == 1), 1'b0, 1'b1};
      end else begin
        idxVal = 17 - b;
        expBeat = {16'd1 << idxVal, 4'(idxVal), 5'd16, (idxVal == 0), 1'b0, 1'b1};
      end
      checkCount++;
      if ({bus.onehot_o, bus.idx_o, bus.cnt_o, bus.last_o, bus.zero_o, bus.val_o} !== expBeat) begin
        errorCount++;
        $display("[TB] FAIL back_to_back beat %0d got %h expected %h", b,
                 {bus.onehot_o, bus.idx_o, bus.cnt_o, bus.last_o, bus.zero_o, bus.val_o}, expBeat);
      end
      if (b < 2) begin
        checkCount++;
        if (bus.data_rdy_o !== (b == 1)) begin
          errorCount++;
          $display("[TB] FAIL back_to_back data_rdy beat %0d got %b expected %b", b, bus.data_rdy_o, (b == 1));
        end
      end
      @(negedge clk);
    end
    #1;
    checkCount++;
    if (bus.val_o !== 1'b0) begin errorCount++; $display("[TB] FAIL back_to_back tail val_o got %b expected 0", bus.val_o); end
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    bus.data_i = 16'hFFFF;
    bus.msb_first_i = 1'b1;
    bus.data_val_i = 1'b1;
    bus.rdy_i = 1'b1;
    @(negedge clk);
    bus.data_val_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkCount++;
    if ({bus.idx_o, bus.val_o} !== {4'd12, 1'b1}) begin
      errorCount++;
      $display("[TB] FAIL midreset pre idx/val got %h expected %h", {bus.idx_o, bus.val_o}, {4'd12, 1'b1});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if ({bus.val_o, bus.onehot_o} !== {1'b0, 16'h0}) begin
      errorCount++;
      $display("[TB] FAIL midreset async val/onehot got %h expected 00000", {bus.val_o, bus.onehot_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkCount++;
    if ({bus.val_o, bus.data_rdy_o} !== 2'b01) begin
      errorCount++;
      $display("[TB] FAIL midreset release val/rdy got %b expected 01", {bus.val_o, bus.data_rdy_o});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkCount++;
      if (bus.val_o !== 1'b0) begin errorCount++; $display("[TB] FAIL midreset stale beat cycle %0d val_o got %b expected 0", i, bus.val_o); end
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    test_reset();
    test_scan_order(1'b1);
    test_scan_order(1'b0);
    test_zero_word();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/priority_scanner.md
Name: priority_scanner

Overview:
- Successor to the single-shot leftmost/rightmost bit encoder.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits every set bit of that word, one per beat, over a second valid/ready handshake.
- Order is highest-priority first, selectable per word: MSB-first or LSB-first.
- Each beat carries a one-hot mask, a binary index and a last flag; the word's popcount is held alongside. Used to serialise request/flag vectors toward arbiters and interrupt dispatch.

Parameters:
- WIDTH, 16, input word width; legal range 2..64.
- IDX_W, $clog2(WIDTH), index output width (derived; do not override).
- CNT_W, $clog2(WIDTH+1), popcount output width (derived).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- data_i  in  WIDTH  word to scan.
- msb_first_i  in  1  1 = scan MSB→LSB, 0 = LSB→MSB; sampled with data_i.
- data_val_i  in  1  data_i/msb_first_i valid.
- data_rdy_o  out  1  block can accept a word.
- onehot_o  out  WIDTH  one-hot of the current emitted bit; all-zero for a zero word.
- idx_o  out  IDX_W  binary index of the current bit.
- cnt_o  out  CNT_W  popcount of the word being scanned.
- last_o  out  1  current beat is the final beat of the word.
- zero_o  out  1  current word was all-zero.
- val_o  out  1  output beat valid.
- rdy_i  in  1  downstream accepts beat.

Behaviour:
- Reset, asynchronous on rst_n_i low:
  - State to IDLE; residual, mode and count registers clear.
  - val_o=0, onehot_o=0, idx_o=0, cnt_o=0, last_o=0, zero_o=0.
  - data_rdy_o=1 once in IDLE.
  - Reset mid-scan discards the word; no further beats are emitted.
- States: IDLE, SCAN.
- data_rdy_o = (state==IDLE) | (val_o & rdy_i & last_o). Combinational; this allows back-to-back words with no bubble.
- Accept: data_val_i & data_rdy_o at a clock edge.
  - Load residual←data_i, mode←msb_first_i, cnt←popcount(data_i), zero←(data_i==0).
  - Go to SCAN.
  - First beat is valid the next cycle (latency 1).
- SCAN, output selection:
  - Current bit is the highest set bit of residual if mode=1, else the lowest set bit.
  - onehot_o and idx_o are decoded from the residual register.
  - last_o=1 when residual has exactly one set bit, or when zero=1.
- SCAN, on val_o & rdy_i:
  - Clear the current bit in residual.
  - If last_o: go to IDLE, or reload and stay in SCAN if a new word is accepted in the same edge.
- Zero word: exactly one beat with onehot_o=0, idx_o=0, cnt_o=0, last_o=1, zero_o=1.
- Backpressure: while val_o & !rdy_i, all beat outputs hold stable. data_val_i is ignored (data_rdy_o=0) except on a last beat being consumed.
- data_val_i with data_rdy_o=0: no effect; upstream must hold the word.
- cnt_o and zero_o are constant for all beats of a word.
- Beats per non-zero word = popcount; indices strictly descending (mode=1) or ascending (mode=0).
- Full-width word (all ones) yields WIDTH beats, ending on index 0 (MSB-first) or WIDTH-1 (LSB-first).
- Implementation guidance:
  - Priority selection by isolate-lowest (x & -x) on the residual, with bit-reverse for MSB-first mode.
  - Index by a one-hot→binary OR-reduce.
  - No loops with variable-dependent exits.

Test Plan:
- Reset then WIDTH=16, data_i=16'h8421, msb_first=1, rdy_i=1 → beats idx 15,10,5,0; onehot 8000,0400,0020,0001; cnt_o=4; last_o only on idx 0; val_o first high 1 cycle after accept.
- Same word with msb_first=0 → idx 0,5,10,15; last on 15.
- data_i=0 → single beat: onehot 0, zero_o=1, last_o=1, cnt_o=0; returns to IDLE.
- 16'h00F0 with rdy_i toggling 1,0,0,1,… → outputs frozen while rdy_i=0, no bit lost or duplicated; data_rdy_o=0 until the last beat is consumed.
- Back-to-back: 16'h0003 then 16'hFFFF held valid → second word accepted on the same edge its predecessor's last beat is consumed; 18 total beats with no idle cycle.
- Assert rst_n_i low asynchronously mid-edge while scanning 16'hFFFF → val_o drops immediately; after release data_rdy_o=1, no stale beats.
